sram_port1_stream_reader: RTL and testbench

Read-only sequencer for the second (read-only) port of the 1 kB dual-port SRAM macro (32 x 256). It sits beside the Wishbone RAM wrapper, which owns port 0. It consumes what that wrapper writes: on a start command it reads a contiguous, wrapping range of words through port 1. The words are buffered in a small FIFO and presented as a valid/ready stream to downstream user logic (LA/IO streaming). This frees port 0 for Wishbone traffic during bulk readout.

---
 rtl/sram_port1_stream_reader.sv | 208 ++++++++++++++++++++
 tb/tb_sram_port1_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port1_stream_reader.sv
// sram_port1_stream_reader
// Reads a contiguous, wrapping range of words through the read-only port 1 of
// the dual-port SRAM macro and presents them as a valid/ready stream.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start_i, abort_i          transfer control (start accepted only in IDLE)
//   base_addr_i, length_i     first word address and word count (0..256)
//   busy_o, done_o            status: not IDLE / one-cycle completion pulse
//   ram_clk1, ram_csb1,       SRAM port 1 clock, active-low select, address
//   ram_addr1, ram_dout1      and read data
//   m_valid_o, m_ready_i,     output stream (FIFO head)
//   m_data_o
module sram_port1_stream_reader #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_clk1,
    output logic              ram_csb1,
    output logic [ADDR_W-1:0] ram_addr1,
    input  logic [DATA_W-1:0] ram_dout1,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]         remaining_q, remaining_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [READ_LATENCY-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0]        mem [FIFO_DEPTH];

    logic                     issue;
    logic                     flush;
    logic                     push;
    logic                     pop;
    logic                     credit_ok;
    logic                     done_d;
    logic                     csb_d;
    logic [ADDR_W-1:0]        addr_d;

    // Port 1 runs on the system clock.
    assign ram_clk1 = wb_clk_i;

    // Stream head is read straight out of the FIFO storage.
    assign m_data_o = mem[rd_ptr_q];

    // Outstanding words (buffered + requested) must fit the FIFO.
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);

    // Next-state, SRAM request and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        rd_addr_d   = base_addr_i;
                        remaining_d = length_i;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if ((remaining_q != '0) && credit_ok) begin
                    issue       = 1'b1;
                    rd_addr_d   = rd_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if ((inflight_q == '0) && (count_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Returning data after an abort is dropped along with the FIFO.
        push = vld_q[READ_LATENCY-1] & ~flush;
        pop  = m_valid_o & m_ready_i & ~flush;

        csb_d  = ~issue;
        addr_d = issue ? rd_addr_q : ram_addr1;

        // Valid pipeline mirrors the SRAM read latency.
        vld_d = '0;
        if (!flush) begin
            vld_d[0] = ~ram_csb1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        inflight_d = inflight_q;
        unique case ({issue, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (flush) begin
            count_d    = '0;
            inflight_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // State and control registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            vld_q       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            ram_csb1    <= 1'b1;
            ram_addr1   <= '0;
            m_valid_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            vld_q       <= vld_d;
            busy_o      <= (state_d != ST_IDLE);
            done_o      <= done_d;
            ram_csb1    <= csb_d;
            ram_addr1   <= addr_d;
            m_valid_o   <= (count_d != '0);
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr_q] <= ram_dout1;
        end
    end

endmodule

// File: tb/tb_sram_port1_stream_reader.sv
// Directed bench for sram_port1_stream_reader with a behavioural port-1 SRAM.
module tb_sram_port1_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, m_ready_i;
    logic [7:0]  base_addr_i;
    logic [8:0]  length_i;
    logic        busy_o, done_o, ram_clk1, ram_csb1, m_valid_o;
    logic [7:0]  ram_addr1;
    logic [31:0] ram_dout1, m_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  addr_q[$];
    logic [31:0] data_q[$];
    int          done_cnt = 0;
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] ram [256];

    sram_port1_stream_reader dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_clk1    (ram_clk1),
        .ram_csb1    (ram_csb1),
        .ram_addr1   (ram_addr1),
        .ram_dout1   (ram_dout1),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input int a);
        if (a >= 16 && a < 20) return 32'(32'hA0 + a - 16);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    // Port-1 SRAM: request captured on the edge, data available for the next edge.
    always @(posedge clk) begin
        if (ram_csb1 === 1'b0) ram_dout1 <= ram[ram_addr1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: issued addresses, accepted words, done pulses, hold stability.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (ram_csb1 === 1'b0) addr_q.push_back(ram_addr1);
            if (m_valid_o && m_ready_i) data_q.push_back(m_data_o);
            if (done_o === 1'b1) done_cnt++;
            if (hold && m_valid_o) chk("stable_data", 64'(m_data_o), 64'(held));
            hold = m_valid_o & ~m_ready_i;
            held = m_data_o;
        end else begin
            hold = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int base, input int len);
        addr_q.delete();
        data_q.delete();
        base_addr_i = 8'(base);
        length_i    = 9'(len);
        start_i     = 1'b1;
        cyc(1);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        chk({tag, "_done"}, 64'(done_o), 64'(1));
        chk({tag, "_busy_at_done"}, 64'(busy_o), 64'(0));
        chk({tag, "_valid_at_done"}, 64'(m_valid_o), 64'(0));
        cyc(1);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'(0));
    endtask

    task automatic check_stream(input string tag, input int base, input int len);
        chk({tag, "_addr_count"}, 64'(addr_q.size()), 64'(len));
        chk({tag, "_word_count"}, 64'(data_q.size()), 64'(len));
        for (int i = 0; i < len; i++) begin
            if (i < addr_q.size())
                chk($sformatf("%s_addr%0d", tag, i), 64'(addr_q[i]), 64'((base + i) & 255));
            if (i < data_q.size())
                chk($sformatf("%s_word%0d", tag, i), 64'(data_q[i]), 64'(exp_word((base + i) & 255)));
        end
    endtask

    initial begin
        int n;
        int d0;
        for (int a = 0; a < 256; a++) ram[a] = exp_word(a);
        ram_dout1   = '0;
        rst         = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        m_ready_i   = 1'b0;
        base_addr_i = '0;
        length_i    = '0;

        // Reset values.
        #2;
        chk("rst_busy",  64'(busy_o),    64'(0));
        chk("rst_done",  64'(done_o),    64'(0));
        chk("rst_csb",   64'(ram_csb1),  64'(1));
        chk("rst_addr",  64'(ram_addr1), 64'(0));
        chk("rst_valid", 64'(m_valid_o), 64'(0));
        chk("rst_data",  64'(m_data_o),  64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);

        // Basic read of 4 words at full rate.
        m_ready_i = 1'b1;
        d0 = done_cnt;
        start(16, 4);
        chk("basic_busy", 64'(busy_o), 64'(1));
        wait_done("basic", 40);
        check_stream("basic", 16, 4);
        chk("basic_done_once", 64'(done_cnt - d0), 64'(1));

        // Backpressure: only FIFO_DEPTH reads go out while stalled.
        m_ready_i = 1'b0;
        start(32, 10);
        cyc(20);
        chk("bp_issued", 64'(addr_q.size()), 64'(4));
        chk("bp_valid",  64'(m_valid_o), 64'(1));
        chk("bp_head",   64'(m_data_o), 64'(exp_word(32)));
        chk("bp_busy",   64'(busy_o), 64'(1));
        m_ready_i = 1'b1;
        wait_done("bp", 60);
        check_stream("bp", 32, 10);

        // Address wrap 0xFE -> 0x01.
        start(254, 4);
        wait_done("wrap", 40);
        check_stream("wrap", 254, 4);

        // Zero length: done next cycle, no SRAM access.
        start(51, 0);
        chk("len0_done", 64'(done_o), 64'(1));
        chk("len0_busy", 64'(busy_o), 64'(0));
        cyc(3);
        chk("len0_no_reads", 64'(addr_q.size()), 64'(0));
        chk("len0_done_pulse", 64'(done_o), 64'(0));

        // Full 256-word sweep from a mid base.
        start(128, 256);
        wait_done("len256", 600);
        check_stream("len256", 128, 256);

        // Abort after three reads with the stream stalled.
        m_ready_i = 1'b0;
        start(64, 8);
        n = 0;
        while (addr_q.size() < 3 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("abort_three_reads", 64'(addr_q.size() >= 3), 64'(1));
        chk("abort_pre_valid", 64'(m_valid_o), 64'(1));
        d0 = done_cnt;
        abort_i = 1'b1;
        start_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_valid", 64'(m_valid_o), 64'(0));
        chk("abort_csb",   64'(ram_csb1),  64'(1));
        chk("abort_busy",  64'(busy_o),    64'(0));
        chk("abort_done",  64'(done_o),    64'(0));
        cyc(4);
        chk("abort_dropped", 64'(m_valid_o), 64'(0));
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        m_ready_i = 1'b1;
        start(80, 2);
        wait_done("post_abort", 40);
        check_stream("post_abort", 80, 2);

        // Asynchronous reset between edges mid-transfer.
        m_ready_i = 1'b0;
        start(96, 8);
        cyc(3);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",  64'(busy_o),    64'(0));
        chk("arst_done",  64'(done_o),    64'(0));
        chk("arst_csb",   64'(ram_csb1),  64'(1));
        chk("arst_addr",  64'(ram_addr1), 64'(0));
        chk("arst_valid", 64'(m_valid_o), 64'(0));
        chk("arst_data",  64'(m_data_o),  64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);
        chk("arst_no_done", 64'(done_cnt - d0), 64'(0));
        m_ready_i = 1'b1;
        start(112, 3);
        wait_done("post_rst", 40);
        check_stream("post_rst", 112, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
